// File: rtl/mem_arbiter.sv
// Arbitrates the shared pipelined memory between I-cache fills and D-cache fills/stores; optional MEM_ARB_ROUND_ROBIN_EN selects alternating tie-break.
// Latency: 1 cycle arbitration in IDLE, then fill issues back-to-back; done coincides with the last returned word.
// Backpressure: requesters hold req until done; a grant is never preempted, losers simply wait in IDLE.
module mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_data_valid,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_data_valid,
    output logic              d_done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_data_valid
);

    localparam int OFF_W = $clog2(BLOCK_WORDS) + 1;
    localparam int CNT_W = $clog2(BLOCK_WORDS) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0] LAST_RET = CNT_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, D_WRITE} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  issue_q;
    logic [CNT_W-1:0]  ret_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic in_fill, issuing, fill_ret, last_ret, take_d;

    function automatic logic [ADDR_W-1:0] blk_base(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_d_q;  // 1 = D won the most recent grant
    assign take_d = d_req && (!i_req || !last_d_q);
`else
    assign take_d = d_req;
`endif

    assign in_fill  = (state_q == I_FILL) || (state_q == D_FILL);
    assign issuing  = in_fill && (issue_q != FULL_CNT);
    assign fill_ret = in_fill && mem_data_valid && !rst;
    assign last_ret = fill_ret && (ret_q == LAST_RET);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            issue_q <= '0;
            ret_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    issue_q <= '0;
                    ret_q   <= '0;
                    if (take_d) begin
                        addr_q  <= d_wr ? d_addr : blk_base(d_addr);
                        wdata_q <= d_wdata;
                        state_q <= d_wr ? D_WRITE : D_FILL;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_d_q <= 1'b1;
`endif
                    end else if (i_req) begin
                        addr_q  <= blk_base(i_addr);
                        state_q <= I_FILL;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_d_q <= 1'b0;
`endif
                    end
                end
                I_FILL, D_FILL: begin
                    if (issuing)  issue_q <= issue_q + 1'b1;
                    if (fill_ret) ret_q   <= ret_q + 1'b1;
                    if (last_ret) state_q <= IDLE;
                end
                D_WRITE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i_gnt        = (state_q == I_FILL);
    assign d_gnt        = (state_q == D_FILL) || (state_q == D_WRITE);
    assign i_data_valid = fill_ret && (state_q == I_FILL);
    assign d_data_valid = fill_ret && (state_q == D_FILL);
    assign i_done       = last_ret && (state_q == I_FILL);
    assign d_done       = (last_ret && (state_q == D_FILL)) || (state_q == D_WRITE);
    assign rdata        = mem_rdata;

    // Word offset is spliced in below the block base so it can never carry upward.
    assign mem_en    = issuing || (state_q == D_WRITE);
    assign mem_wr    = (state_q == D_WRITE);
    assign mem_addr  = issuing ? {addr_q[ADDR_W-1:OFF_W], issue_q[CNT_W-2:0], 1'b0}
                     : (state_q == D_WRITE) ? addr_q : '0;
    assign mem_wdata = (state_q == D_WRITE) ? wdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a 4-cycle in-order memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_gnt, i_data_valid, i_done;
    logic        d_gnt, d_data_valid, d_done;
    logic [15:0] rdata, mem_addr, mem_wdata;
    logic        mem_en, mem_wr;
    logic [15:0] mem_rdata = '0;
    logic        mem_data_valid = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        own_d;
        logic [15:0] data;
    } ret_t;

    logic [15:0] exp_addr_q[$];
    ret_t        exp_ret_q[$];

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_data_valid(i_data_valid), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_data_valid(d_data_valid), .d_done(d_done),
        .rdata(rdata), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    function automatic logic [39:0] all_outs();
        return {i_gnt, i_data_valid, i_done, d_gnt, d_data_valid, d_done,
                mem_en, mem_wr, mem_addr, mem_wdata};
    endfunction

    // Memory model: read issued in cycle c returns in cycle c+4.
    logic        cap_v = 1'b0;
    logic [15:0] cap_a = '0;
    logic        pv[4] = '{default: 1'b0};
    logic [15:0] pa[4] = '{default: 16'h0};

    always @(negedge clk) begin
        cap_v = (mem_en === 1'b1) && (mem_wr === 1'b0);
        cap_a = mem_addr;
    end

    always @(posedge clk) begin
        #1;
        for (int s = 3; s > 0; s--) begin
            pv[s] = pv[s-1];
            pa[s] = pa[s-1];
        end
        pv[0] = cap_v;
        pa[0] = cap_a;
        mem_data_valid = pv[3];
        mem_rdata      = pv[3] ? mem_fn(pa[3]) : 16'h0;
    end

    // Scoreboard monitor: issued read addresses and returned words.
    always @(negedge clk) begin
        logic [15:0] ea;
        ret_t        er;
        if (mem_en === 1'b1 && mem_wr === 1'b0) begin
            checks++;
            if (exp_addr_q.size() == 0) begin
                errors++;
                $display("FAIL rd_addr: unexpected read at %h", mem_addr);
            end else begin
                ea = exp_addr_q.pop_front();
                if (mem_addr !== ea) begin
                    errors++;
                    $display("FAIL rd_addr: got %h expected %h", mem_addr, ea);
                end
            end
        end
        if (i_data_valid === 1'b1 || d_data_valid === 1'b1) begin
            checks++;
            if (exp_ret_q.size() == 0) begin
                errors++;
                $display("FAIL rd_data: unexpected valid i=%b d=%b", i_data_valid, d_data_valid);
            end else begin
                er = exp_ret_q.pop_front();
                if ({d_data_valid, i_data_valid, rdata} !== {er.own_d, !er.own_d, er.data}) begin
                    errors++;
                    $display("FAIL rd_data: got d=%b i=%b %h expected d=%b %h",
                             d_data_valid, i_data_valid, rdata, er.own_d, er.data);
                end
            end
        end
    end

    task automatic push_fill(input logic own_d, input logic [15:0] addr, input int nwords);
        logic [15:0] base;
        ret_t r;
        base = addr & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
            if (k < nwords) exp_addr_q.push_back(base + 16'(2 * k));
            if (nwords == 8) begin
                r.own_d = own_d;
                r.data  = mem_fn(base + 16'(2 * k));
                exp_ret_q.push_back(r);
            end
        end
    endtask

    task automatic wait_done(input logic own_d, input string name);
        int  beats = 0;
        logic seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            checks++;
            if (own_d ? ({d_gnt, i_gnt, i_data_valid, i_done} !== 4'b1000)
                      : ({i_gnt, d_gnt, d_data_valid, d_done} !== 4'b1000)) begin
                errors++;
                $display("FAIL %s_gnt_excl: i_gnt=%b d_gnt=%b i_dv=%b d_dv=%b",
                         name, i_gnt, d_gnt, i_data_valid, d_data_valid);
            end
            if (own_d ? d_data_valid : i_data_valid) beats++;
            if (own_d ? d_done : i_done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done: timeout, got no done expected done", name);
        end
        checks++;
        if (beats != 8) begin
            errors++;
            $display("FAIL %s_beats: got %0d expected 8", name, beats);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_addr_q.size() != 0 || exp_ret_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d addr / %0d data left, expected 0",
                     name, exp_addr_q.size(), exp_ret_q.size());
            exp_addr_q.delete();
            exp_ret_q.delete();
        end
    endtask

    task automatic run_i_fill(input logic [15:0] addr, input string name);
        @(posedge clk); #1;
        i_req  = 1'b1;
        i_addr = addr;
        push_fill(1'b0, addr, 8);
        @(negedge clk);
        checks++;
        if ({i_gnt, mem_en} !== 2'b00) begin
            errors++;
            $display("FAIL %s_arb: got gnt=%b mem_en=%b expected 0 0", name, i_gnt, mem_en);
        end
        @(negedge clk);
        checks++;
        if (i_gnt !== 1'b1) begin
            errors++;
            $display("FAIL %s_gnt: got %b expected 1", name, i_gnt);
        end
        wait_done(1'b0, name);
        @(posedge clk); #1;
        i_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({i_gnt, mem_en} !== 2'b00) begin
            errors++;
            $display("FAIL %s_release: got gnt=%b mem_en=%b expected 0 0", name, i_gnt, mem_en);
        end
        repeat (6) @(negedge clk);
        check_drained(name);
    endtask

    task automatic test_reset();
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (all_outs() !== 40'd0) begin
            errors++;
            $display("FAIL reset_outs: got %h expected 0", all_outs());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (all_outs() !== 40'd0) begin
            errors++;
            $display("FAIL idle_outs: got %h expected 0", all_outs());
        end
    endtask

    task automatic test_i_fill();
        run_i_fill(16'h1234, "ifill");
    endtask

    task automatic test_wrap();
        run_i_fill(16'hFFF6, "wrap");
    endtask

    task automatic test_tie();
        int n;
        @(posedge clk); #1;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h4000;
        i_req = 1'b1; i_addr = 16'h0010;
        push_fill(1'b1, 16'h4000, 8);
        push_fill(1'b0, 16'h0010, 8);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({d_gnt, i_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL tie_winner: got d=%b i=%b expected d=1 i=0", d_gnt, i_gnt);
        end
        wait_done(1'b1, "tie_d");
        @(posedge clk); #1;
        d_req = 1'b0;
        for (n = 0; n < 10; n++) begin
            @(negedge clk);
            if (i_gnt === 1'b1) break;
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL tie_i_gnt_delay: got %0d cycles expected 1", n);
        end
        wait_done(1'b0, "tie_i");
        @(posedge clk); #1;
        i_req = 1'b0;
        repeat (6) @(negedge clk);
        check_drained("tie");
    endtask

    task automatic test_write();
        @(posedge clk); #1;
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h00A2; d_wdata = 16'hBEEF;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0) begin
            errors++;
            $display("FAIL wr_idle: got mem_en=%b expected 0", mem_en);
        end
        @(negedge clk);
        checks++;
        if ({mem_en, mem_wr, mem_addr, mem_wdata, d_gnt, d_done, d_data_valid, i_gnt}
            !== {1'b1, 1'b1, 16'h00A2, 16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL wr_beat: got en=%b wr=%b a=%h d=%h gnt=%b done=%b dv=%b expected 1 1 00a2 beef 1 1 0",
                     mem_en, mem_wr, mem_addr, mem_wdata, d_gnt, d_done, d_data_valid);
        end
        @(posedge clk); #1;
        d_req = 1'b0; d_wr = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_en, d_gnt, d_done} !== 3'b000) begin
            errors++;
            $display("FAIL wr_single: got en=%b gnt=%b done=%b expected 0 0 0", mem_en, d_gnt, d_done);
        end
    endtask

    task automatic test_reset_mid();
        int strays = 0;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 16'h0100;
        push_fill(1'b0, 16'h0100, 3);
        @(negedge clk);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; i_req = 1'b0;
        @(negedge clk);
        checks++;
        if (all_outs() !== 40'd0) begin
            errors++;
            $display("FAIL rstmid_outs: got %h expected 0", all_outs());
        end
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (mem_data_valid) strays++;
            checks++;
            if ({i_gnt, i_data_valid, i_done, mem_en} !== 4'b0000) begin
                errors++;
                $display("FAIL rstmid_quiet: got gnt=%b dv=%b done=%b en=%b expected 0",
                         i_gnt, i_data_valid, i_done, mem_en);
            end
        end
        checks++;
        if (strays != 3) begin
            errors++;
            $display("FAIL rstmid_strays: got %0d expected 3", strays);
        end
        check_drained("rstmid");
        run_i_fill(16'h0100, "rstmid_refill");
    endtask

    task automatic test_round_robin();
        logic exp_own[4];
        logic got_own[4];
        int   grants = 0;
        int   dones = 0;
        logic prev = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_own = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_own = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        @(posedge clk); #1;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h2000;
        i_req = 1'b1; i_addr = 16'h3000;
        for (int g = 0; g < 4; g++) push_fill(exp_own[g], exp_own[g] ? 16'h2000 : 16'h3000, 8);
        for (int n = 0; n < 300 && dones < 4; n++) begin
            @(negedge clk);
            if ((i_gnt || d_gnt) && !prev && grants < 4) begin
                got_own[grants] = d_gnt;
                grants++;
            end
            prev = i_gnt || d_gnt;
            if (i_done || d_done) dones++;
        end
        @(posedge clk); #1;
        d_req = 1'b0; i_req = 1'b0;
        checks++;
        if (grants != 4) begin
            errors++;
            $display("FAIL rr_grants: got %0d expected 4", grants);
        end
        for (int g = 0; g < grants; g++) begin
            checks++;
            if (got_own[g] !== exp_own[g]) begin
                errors++;
                $display("FAIL rr_order[%0d]: got d=%b expected d=%b", g, got_own[g], exp_own[g]);
            end
        end
        repeat (8) @(negedge clk);
        check_drained("rr");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_i_fill();
        test_tie();
        test_write();
        test_reset_mid();
        test_wrap();
        test_round_robin();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
